// File: rtl/counter_prog_if.sv
// rtl/counter_prog_if.sv - control and status bundle for the programmable counter
interface counter_prog_if #(
    parameter int N = 8
);
    logic         EN;
    logic         UP_DOWN;
    logic [N-1:0] STEP;
    logic [1:0]   MODE;
    logic         LOAD;
    logic [N-1:0] LOAD_VAL;
    logic         SET_MOD;
    logic [N-1:0] MOD_VAL;
    logic [N-1:0] COUNT;
    logic [N-1:0] MAXV;
    logic         TC;
    logic         DONE;

    modport master (
        output EN, UP_DOWN, STEP, MODE, LOAD, LOAD_VAL, SET_MOD, MOD_VAL,
        input  COUNT, MAXV, TC, DONE
    );

    modport slave (
        input  EN, UP_DOWN, STEP, MODE, LOAD, LOAD_VAL, SET_MOD, MOD_VAL,
        output COUNT, MAXV, TC, DONE
    );
endinterface

// File: rtl/counter_prog.sv
// rtl/counter_prog.sv - up/down counter with programmable modulus, step, load and end-of-count modes
module counter_prog #(
    parameter int N = 8,
    parameter int M = 32
) (
    input  logic          CLK,
    input  logic          RST,
    counter_prog_if.slave bus
);
    localparam logic [N-1:0] MAXV_RST = N'(M - 1);
    localparam logic [N-1:0] ONE      = N'(1);

    logic [N-1:0] r_count;
    logic [N-1:0] r_maxv;
    logic         r_done;

    logic [N-1:0] w_step;
    logic [N:0]   w_sum;
    logic         w_cross;
    logic         w_sat_mode;
    logic         w_one_shot;
    logic         w_at_bound;
    logic         w_tc;
    logic [N-1:0] w_up_wrap;
    logic [N-1:0] w_dn_wrap;
    logic [N-1:0] w_count_step;
    logic [N-1:0] w_load_lim;
    logic [N-1:0] w_load_val;

    always_comb begin
        w_step = bus.STEP;
        if (bus.STEP == '0) begin
            w_step = ONE;
        end else if (bus.STEP > r_maxv) begin
            w_step = r_maxv;
        end

        w_sum      = {1'b0, r_count} + {1'b0, w_step};
        // A zero limit pins the count at 0, so every enabled cycle counts as a crossing
        w_cross    = (r_maxv == '0) ||
                     (bus.UP_DOWN ? (w_sum > {1'b0, r_maxv}) : (r_count < w_step));
        w_sat_mode = (bus.MODE == 2'b01) || (bus.MODE == 2'b10);
        w_one_shot = (bus.MODE == 2'b10);
        w_at_bound = bus.UP_DOWN ? (r_count == r_maxv) : (r_count == '0);

        // Modular N-bit arithmetic is exact here: both wrap results lie in 0..MAXV
        w_up_wrap  = r_count + w_step - r_maxv - ONE;
        w_dn_wrap  = r_count + r_maxv + ONE - w_step;

        w_count_step = r_count;
        if (r_maxv == '0) begin
            w_count_step = '0;
        end else if (!w_cross) begin
            w_count_step = bus.UP_DOWN ? w_sum[N-1:0] : (r_count - w_step);
        end else if (w_sat_mode) begin
            w_count_step = bus.UP_DOWN ? r_maxv : '0;
        end else begin
            w_count_step = bus.UP_DOWN ? w_up_wrap : w_dn_wrap;
        end

        w_load_lim = bus.SET_MOD ? bus.MOD_VAL : r_maxv;
        w_load_val = (bus.LOAD_VAL > w_load_lim) ? w_load_lim : bus.LOAD_VAL;

        // Saturating modes suppress TC while already parked at the bound
        w_tc = bus.EN && !RST && !bus.LOAD && !bus.SET_MOD && !r_done &&
               w_cross && !(w_sat_mode && w_at_bound);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_count <= '0;
            r_maxv  <= MAXV_RST;
            r_done  <= 1'b0;
        end else if (bus.LOAD || bus.SET_MOD) begin
            if (bus.SET_MOD) begin
                r_maxv <= bus.MOD_VAL;
            end
            if (bus.LOAD) begin
                r_count <= w_load_val;
                r_done  <= 1'b0;
            end else if (r_count > bus.MOD_VAL) begin
                r_count <= bus.MOD_VAL;
            end
        end else if (bus.EN && !r_done) begin
            r_count <= w_count_step;
            if (w_one_shot && w_cross) begin
                r_done <= 1'b1;
            end
        end
    end

    assign bus.COUNT = r_count;
    assign bus.MAXV  = r_maxv;
    assign bus.DONE  = r_done;
    assign bus.TC    = w_tc;
endmodule

// File: tb/tb_counter_prog.sv
// tb/tb_counter_prog.sv - randomized and directed self-checking bench for counter_prog
module tb_counter_prog;
    logic CLK;
    logic RST;
    int   n_checks;
    int   n_errors;

    int   m_cnt;
    int   m_maxv;
    int   m_done;
    bit   exp_tc;
    logic obs_tc;

    counter_prog_if #(.N(8)) bus ();

    counter_prog #(.N(8), .M(32)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic tick();
        int s;
        bit x;
        bit up;
        int mode;
        int lim;
        #1;
        up   = bus.UP_DOWN;
        mode = (bus.MODE == 2'd3) ? 0 : int'(bus.MODE);
        s    = (bus.STEP == 0) ? 1 : ((int'(bus.STEP) > m_maxv) ? m_maxv : int'(bus.STEP));
        if (m_maxv == 0) x = 1;
        else if (up)     x = (m_cnt + s > m_maxv);
        else             x = (m_cnt < s);
        exp_tc = bus.EN && !RST && !bus.LOAD && !bus.SET_MOD && (m_done == 0) && x &&
                 !((mode != 0) && (m_cnt == (up ? m_maxv : 0)));
        obs_tc = bus.TC;
        @(posedge CLK);
        if (RST) begin
            m_cnt = 0; m_maxv = 31; m_done = 0;
        end else if (bus.LOAD || bus.SET_MOD) begin
            lim = bus.SET_MOD ? int'(bus.MOD_VAL) : m_maxv;
            if (bus.LOAD) begin
                m_cnt  = (int'(bus.LOAD_VAL) < lim) ? int'(bus.LOAD_VAL) : lim;
                m_done = 0;
            end else if (m_cnt > int'(bus.MOD_VAL)) begin
                m_cnt = int'(bus.MOD_VAL);
            end
            if (bus.SET_MOD) m_maxv = int'(bus.MOD_VAL);
        end else if (bus.EN && m_done == 0) begin
            if (m_maxv == 0)    m_cnt = 0;
            else if (!x)        m_cnt = up ? m_cnt + s : m_cnt - s;
            else if (mode == 0) m_cnt = up ? (m_cnt + s) % (m_maxv + 1) : m_cnt + m_maxv + 1 - s;
            else                m_cnt = up ? m_maxv : 0;
            if (mode == 2 && x) m_done = 1;
        end
        #1;
    endtask

    task automatic idle_inputs();
        RST = 0; bus.EN = 0; bus.LOAD = 0; bus.SET_MOD = 0;
    endtask

    task automatic test_reset();
        RST = 1; bus.EN = 1; bus.UP_DOWN = 1; bus.STEP = 8'd1; bus.MODE = 2'd0;
        bus.LOAD = 0; bus.LOAD_VAL = 0; bus.SET_MOD = 0; bus.MOD_VAL = 0;
        tick();
        n_checks++;
        if (bus.COUNT !== 8'd0 || bus.MAXV !== 8'd31 || bus.DONE !== 1'b0 || obs_tc !== 1'b0) begin
            n_errors++;
            $display("FAIL reset: count=%0d maxv=%0d done=%b tc=%b, want 0 31 0 0", bus.COUNT, bus.MAXV, bus.DONE, obs_tc);
        end
        RST = 0;
    endtask

    task automatic test_wrap_up();
        bus.EN = 1; bus.UP_DOWN = 1; bus.STEP = 8'd1; bus.MODE = 2'd0;
        for (int i = 0; i < 33; i++) begin
            n_checks++;
            if (bus.COUNT !== 8'(i % 32)) begin
                n_errors++;
                $display("FAIL wrap_up count[%0d]: got %0d want %0d", i, bus.COUNT, i % 32);
            end
            tick();
            n_checks++;
            if (obs_tc !== ((i % 32) == 31) || obs_tc !== exp_tc) begin
                n_errors++;
                $display("FAIL wrap_up tc[%0d]: got %b want %b", i, obs_tc, (i % 32) == 31);
            end
        end
        idle_inputs();
    endtask

    task automatic test_down_wrap();
        int seq[6] = '{2, 9, 6, 3, 0, 7};
        bus.SET_MOD = 1; bus.MOD_VAL = 8'd9; bus.LOAD = 1; bus.LOAD_VAL = 8'd2;
        tick();
        idle_inputs();
        bus.EN = 1; bus.UP_DOWN = 0; bus.STEP = 8'd3; bus.MODE = 2'd0;
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (bus.COUNT !== 8'(seq[i]) || bus.MAXV !== 8'd9) begin
                n_errors++;
                $display("FAIL down_wrap count[%0d]: got %0d want %0d", i, bus.COUNT, seq[i]);
            end
            tick();
            n_checks++;
            if (obs_tc !== (seq[i] == 2 || seq[i] == 0)) begin
                n_errors++;
                $display("FAIL down_wrap tc[%0d]: got %b want %b", i, obs_tc, seq[i] == 2 || seq[i] == 0);
            end
        end
        n_checks++;
        if (bus.COUNT !== 8'd7) begin
            n_errors++;
            $display("FAIL down_wrap final: got %0d want 7", bus.COUNT);
        end
        idle_inputs();
    endtask

    task automatic test_one_shot();
        int pulses;
        int exp_pulses;
        bus.LOAD = 1; bus.LOAD_VAL = 8'd7;
        tick();
        idle_inputs();
        bus.EN = 1; bus.UP_DOWN = 1; bus.STEP = 8'd2; bus.MODE = 2'd2;
        pulses = 0; exp_pulses = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            pulses += int'(obs_tc);
            exp_pulses += int'(exp_tc);
        end
        n_checks++;
        if (bus.COUNT !== 8'd9 || bus.DONE !== 1'b1 || pulses !== exp_pulses) begin
            n_errors++;
            $display("FAIL one_shot from 7: count=%0d done=%b tc_pulses=%0d want 9 1 %0d", bus.COUNT, bus.DONE, pulses, exp_pulses);
        end
        bus.EN = 0; bus.LOAD = 1; bus.LOAD_VAL = 8'd8;
        tick();
        bus.LOAD = 0; bus.EN = 1;
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            pulses += int'(obs_tc);
        end
        n_checks++;
        if (bus.COUNT !== 8'd9 || bus.DONE !== 1'b1 || pulses !== 1) begin
            n_errors++;
            $display("FAIL one_shot from 8: count=%0d done=%b tc_pulses=%0d want 9 1 1", bus.COUNT, bus.DONE, pulses);
        end
        bus.EN = 0; bus.LOAD = 1; bus.LOAD_VAL = 8'd0;
        tick();
        n_checks++;
        if (bus.DONE !== 1'b0 || bus.COUNT !== 8'd0) begin
            n_errors++;
            $display("FAIL one_shot load clears: done=%b count=%0d want 0 0", bus.DONE, bus.COUNT);
        end
        bus.LOAD = 0; bus.EN = 1;
        tick();
        n_checks++;
        if (bus.COUNT !== 8'd2) begin
            n_errors++;
            $display("FAIL one_shot resume: got %0d want 2", bus.COUNT);
        end
        idle_inputs();
        bus.MODE = 2'd0;
    endtask

    task automatic test_mod_shrink();
        bus.SET_MOD = 1; bus.MOD_VAL = 8'd31; bus.LOAD = 1; bus.LOAD_VAL = 8'd20;
        tick();
        bus.LOAD = 0; bus.MOD_VAL = 8'd15;
        tick();
        n_checks++;
        if (bus.COUNT !== 8'd15 || bus.MAXV !== 8'd15) begin
            n_errors++;
            $display("FAIL mod_shrink: count=%0d maxv=%0d want 15 15", bus.COUNT, bus.MAXV);
        end
        bus.MOD_VAL = 8'd31;
        tick();
        bus.LOAD = 1; bus.LOAD_VAL = 8'd25; bus.MOD_VAL = 8'd15;
        tick();
        n_checks++;
        if (bus.COUNT !== 8'd15 || bus.MAXV !== 8'd15) begin
            n_errors++;
            $display("FAIL mod_shrink_load: count=%0d maxv=%0d want 15 15", bus.COUNT, bus.MAXV);
        end
        idle_inputs();
    endtask

    task automatic test_step_clamp();
        bus.SET_MOD = 1; bus.MOD_VAL = 8'd4; bus.LOAD = 1; bus.LOAD_VAL = 8'd0;
        tick();
        idle_inputs();
        bus.EN = 1; bus.UP_DOWN = 1; bus.MODE = 2'd0; bus.STEP = 8'd0;
        tick();
        n_checks++;
        if (bus.COUNT !== 8'd1) begin
            n_errors++;
            $display("FAIL step_zero: got %0d want 1", bus.COUNT);
        end
        bus.STEP = 8'd200;
        tick();
        n_checks++;
        if (bus.COUNT !== 8'd0 || obs_tc !== 1'b1) begin
            n_errors++;
            $display("FAIL step_clamp: count=%0d tc=%b want 0 1", bus.COUNT, obs_tc);
        end
        bus.EN = 0; bus.SET_MOD = 1; bus.MOD_VAL = 8'd0;
        tick();
        bus.SET_MOD = 0; bus.EN = 1;
        for (int i = 0; i < 4; i++) begin
            bus.STEP = 8'($urandom_range(0, 255));
            bus.UP_DOWN = 1'($urandom_range(0, 1));
            tick();
            n_checks++;
            if (bus.COUNT !== 8'd0 || obs_tc !== 1'b1) begin
                n_errors++;
                $display("FAIL maxv_zero[%0d]: count=%0d tc=%b want 0 1", i, bus.COUNT, obs_tc);
            end
        end
        idle_inputs();
    endtask

    task automatic test_mid_reset();
        bus.SET_MOD = 1; bus.MOD_VAL = 8'd20; bus.LOAD = 1; bus.LOAD_VAL = 8'd5;
        tick();
        idle_inputs();
        bus.EN = 1; bus.UP_DOWN = 1; bus.STEP = 8'd3;
        tick();
        tick();
        RST = 1; bus.LOAD = 1; bus.LOAD_VAL = 8'd9; bus.SET_MOD = 1; bus.MOD_VAL = 8'd12;
        tick();
        n_checks++;
        if (bus.COUNT !== 8'd0 || bus.MAXV !== 8'd31 || bus.DONE !== 1'b0 || obs_tc !== 1'b0) begin
            n_errors++;
            $display("FAIL mid_reset: count=%0d maxv=%0d done=%b tc=%b want 0 31 0 0", bus.COUNT, bus.MAXV, bus.DONE, obs_tc);
        end
        idle_inputs();
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            RST          = ($urandom_range(0, 59) == 0);
            bus.LOAD     = ($urandom_range(0, 11) == 0);
            bus.SET_MOD  = ($urandom_range(0, 13) == 0);
            bus.EN       = ($urandom_range(0, 4) != 0);
            bus.UP_DOWN  = 1'($urandom_range(0, 1));
            bus.MODE     = 2'($urandom_range(0, 3));
            bus.STEP     = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 6));
            bus.LOAD_VAL = 8'($urandom_range(0, 255));
            bus.MOD_VAL  = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 24));
            tick();
            n_checks++;
            if (obs_tc !== exp_tc || bus.COUNT !== 8'(m_cnt) || bus.MAXV !== 8'(m_maxv) || bus.DONE !== 1'(m_done)) begin
                n_errors++;
                $display("FAIL random[%0d]: tc=%b count=%0d maxv=%0d done=%b want %b %0d %0d %0d",
                         i, obs_tc, bus.COUNT, bus.MAXV, bus.DONE, exp_tc, m_cnt, m_maxv, m_done);
            end
        end
        idle_inputs();
    endtask

    initial begin
        n_checks = 0; n_errors = 0;
        m_cnt = 0; m_maxv = 31; m_done = 0;
        test_reset();
        test_wrap_up();
        test_down_wrap();
        test_one_shot();
        test_mod_shrink();
        test_step_clamp();
        test_mid_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
